// File: rtl/axi_hdr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_hdr_pkg
// Purpose  : Shared types and helpers for the header-insert arbiter and its
//            neighbours (benches, inserter checker).
// Revision : 1.0 - initial release
// ============================================================================
package axi_hdr_pkg;

  // Arbiter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    BUSY  = 2'd2
  } hdr_state_e;

  // Plain-vector encodings of the same states for the state register
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OFFER = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  // Keep mask implied by a byte count: count n means n+1 valid low bytes.
  // A count too large for 32 bits saturates to all ones.
  function automatic logic [31:0] keep_from_cnt(input logic [31:0] cnt);
    keep_from_cnt = (32'd1 << (cnt + 32'd1)) - 32'd1;
  endfunction

endpackage : axi_hdr_pkg
`default_nettype wire

// File: rtl/hdr_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hdr_rr_arbiter
// Purpose  : Combinational round-robin picker. Searches upward from the slot
//            after ptr (with wrap) and returns the first active request.
// Revision : 1.0 - initial release
// ============================================================================
module hdr_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REQ_ID_WD = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [REQ_ID_WD-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt_onehot,
  output logic [REQ_ID_WD-1:0] gnt_idx,
  output logic                 any
);

  logic [REQ_ID_WD-1:0] cand;

  // Walk candidates ptr+1 .. ptr+NUM_REQ; the first hit wins
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = REQ_ID_WD'((32'(ptr) + 32'(k)) % 32'(NUM_REQ));
      if (!any && req[cand]) begin
        any              = 1'b1;
        gnt_idx          = cand;
        gnt_onehot[cand] = 1'b1;
      end
    end
  end

endmodule : hdr_rr_arbiter
`default_nettype wire

// File: rtl/axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_stream_header_arbiter
// Purpose  : Shares the single header-insert port of the stream inserter
//            among NUM_REQ header sources, one header per packet, holding the
//            grant until the inserter's payload input completes its last beat.
// Revision : 1.0 - initial release
// ============================================================================
module axi_stream_header_arbiter
  import axi_hdr_pkg::*;
#(
  parameter int DATA_WD      = 16,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int NUM_REQ      = 4,
  parameter int REQ_ID_WD    = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WD-1:0]      req_data,
  input  logic [NUM_REQ*DATA_BYTE_WD-1:0] req_keep,
  input  logic [NUM_REQ*BYTE_CNT_WD-1:0]  req_byte_cnt,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            valid_insert,
  output logic [DATA_WD-1:0]              data_insert,
  output logic [DATA_BYTE_WD-1:0]         keep_insert,
  output logic [BYTE_CNT_WD-1:0]          byte_insert_cnt,
  input  logic                            ready_insert,
  input  logic                            mon_valid_in,
  input  logic                            mon_ready_in,
  input  logic                            mon_last_in,
  output logic [REQ_ID_WD-1:0]            grant_id,
  output logic                            grant_active,
  output logic                            hdr_err
);

  logic [1:0]              state_q, state_d;
  logic                    pend_q, pend_d;
  logic [REQ_ID_WD-1:0]    rr_ptr_q;
  logic [REQ_ID_WD-1:0]    gid_q;
  logic [DATA_WD-1:0]      data_q;
  logic [DATA_BYTE_WD-1:0] keep_q;
  logic [BYTE_CNT_WD-1:0]  cnt_q;
  logic                    err_q;

  logic                    w_pkt_end;
  logic                    w_idle;
  logic                    w_capture;
  logic                    w_any;
  logic [NUM_REQ-1:0]      w_gnt_onehot;
  logic [REQ_ID_WD-1:0]    w_gnt_idx;
  logic [DATA_WD-1:0]      w_sel_data;
  logic [DATA_BYTE_WD-1:0] w_sel_keep;
  logic [BYTE_CNT_WD-1:0]  w_sel_cnt;
  logic [31:0]             w_keep_exp;
  logic                    w_keep_bad;

  logic [DATA_WD-1:0]      w_data_arr [NUM_REQ];
  logic [DATA_BYTE_WD-1:0] w_keep_arr [NUM_REQ];
  logic [BYTE_CNT_WD-1:0]  w_cnt_arr  [NUM_REQ];

  // Split the packed requester buses into per-requester slots
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_data_arr[i] = req_data[i*DATA_WD +: DATA_WD];
    assign w_keep_arr[i] = req_keep[i*DATA_BYTE_WD +: DATA_BYTE_WD];
    assign w_cnt_arr[i]  = req_byte_cnt[i*BYTE_CNT_WD +: BYTE_CNT_WD];
  end

  hdr_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .REQ_ID_WD (REQ_ID_WD)
  ) u_rr (
    .req        (req_valid),
    .ptr        (rr_ptr_q),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .any        (w_any)
  );

  assign w_pkt_end  = mon_valid_in & mon_ready_in & mon_last_in;
  // Reset gates the strobe so no requester believes it was captured
  assign w_idle     = rst_n & (state_q == ST_IDLE);
  assign w_capture  = w_idle & w_any;

  assign w_sel_data = w_data_arr[w_gnt_idx];
  assign w_sel_keep = w_keep_arr[w_gnt_idx];
  assign w_sel_cnt  = w_cnt_arr[w_gnt_idx];
  // A count beyond the bus width also reads as inconsistent
  assign w_keep_exp = keep_from_cnt(32'(w_sel_cnt));
  assign w_keep_bad = (32'(w_sel_keep) != w_keep_exp);

  // Next-state logic; pend_d remembers a packet end seen before the accept
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any) state_d = ST_OFFER;
      end
      ST_OFFER: begin
        if (ready_insert) begin
          state_d = (pend_q | w_pkt_end) ? ST_IDLE : ST_BUSY;
          pend_d  = 1'b0;
        end else if (w_pkt_end) begin
          pend_d  = 1'b1;
        end
      end
      ST_BUSY: begin
        if (w_pkt_end) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State, capture registers and the one-cycle keep-error pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= 1'b0;
      rr_ptr_q <= REQ_ID_WD'(NUM_REQ - 1);
      gid_q    <= '0;
      data_q   <= '0;
      keep_q   <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      err_q   <= w_capture & w_keep_bad;
      if (w_capture) begin
        rr_ptr_q <= w_gnt_idx;
        gid_q    <= w_gnt_idx;
        data_q   <= w_sel_data;
        keep_q   <= w_sel_keep;
        cnt_q    <= w_sel_cnt;
      end
    end
  end

  assign req_ready       = {NUM_REQ{w_idle}} & w_gnt_onehot;
  assign valid_insert    = (state_q == ST_OFFER);
  assign grant_active    = (state_q != ST_IDLE);
  assign grant_id        = gid_q;
  assign data_insert     = data_q;
  assign keep_insert     = keep_q;
  assign byte_insert_cnt = cnt_q;
  assign hdr_err         = err_q;

endmodule : axi_stream_header_arbiter
`default_nettype wire

// File: tb/tb_axi_stream_header_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_stream_header_arbiter
// Purpose  : Self-checking bench: directed vector table, hand sequences and
//            randomized traffic against a packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_stream_header_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;
  localparam int BW = 2;
  localparam int CW = 1;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N*BW-1:0] req_keep;
  logic [N*CW-1:0] req_byte_cnt;
  logic [N-1:0]    req_ready;
  logic            valid_insert;
  logic [DW-1:0]   data_insert;
  logic [BW-1:0]   keep_insert;
  logic [CW-1:0]   byte_insert_cnt;
  logic            ready_insert;
  logic            mon_valid_in, mon_ready_in, mon_last_in;
  logic [IW-1:0]   grant_id;
  logic            grant_active;
  logic            hdr_err;

  logic [DW-1:0] hd [N];
  logic [BW-1:0] hk [N];
  logic [CW-1:0] hc [N];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Pack the per-requester header slots onto the DUT buses
  always_comb begin
    req_data     = '0;
    req_keep     = '0;
    req_byte_cnt = '0;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW]     = hd[i];
      req_keep[i*BW +: BW]     = hk[i];
      req_byte_cnt[i*CW +: CW] = hc[i];
    end
  end

  axi_stream_header_arbiter #(
    .DATA_WD (DW),
    .NUM_REQ (N)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_keep        (req_keep),
    .req_byte_cnt    (req_byte_cnt),
    .req_ready       (req_ready),
    .valid_insert    (valid_insert),
    .data_insert     (data_insert),
    .keep_insert     (keep_insert),
    .byte_insert_cnt (byte_insert_cnt),
    .ready_insert    (ready_insert),
    .mon_valid_in    (mon_valid_in),
    .mon_ready_in    (mon_ready_in),
    .mon_last_in     (mon_last_in),
    .grant_id        (grant_id),
    .grant_active    (grant_active),
    .hdr_err         (hdr_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: packet-level bookkeeping ----------------
  bit          m_has_grant;   // a requester owns the insert port
  bit          m_hdr_waiting; // its header has not yet been accepted
  bit          m_end_early;   // its packet already ended before the accept
  int          m_last;        // most recently served requester
  int          m_gid;
  logic [DW-1:0] m_d;
  logic [BW-1:0] m_k;
  logic [CW-1:0] m_c;
  bit          m_err;

  function automatic int rr_pick(input logic [N-1:0] rv, input int last);
    for (int k = 1; k <= N; k++)
      if (rv[2'((last + k) % N)]) return (last + k) % N;
    return -1;
  endfunction

  task automatic model_check();
    int w;
    logic [N-1:0] exp_rr;
    w = rr_pick(req_valid, m_last);
    exp_rr = (rst_n && !m_has_grant && w >= 0) ? (N'(1) << w) : '0;
    chk("req_ready",       64'(req_ready),       64'(exp_rr));
    chk("valid_insert",    64'(valid_insert),    64'(m_has_grant && m_hdr_waiting));
    chk("grant_active",    64'(grant_active),    64'(m_has_grant));
    chk("grant_id",        64'(grant_id),        64'(m_gid));
    chk("data_insert",     64'(data_insert),     64'(m_d));
    chk("keep_insert",     64'(keep_insert),     64'(m_k));
    chk("byte_insert_cnt", 64'(byte_insert_cnt), 64'(m_c));
    chk("hdr_err",         64'(hdr_err),         64'(m_err));
  endtask

  task automatic model_step();
    bit pe;
    int w;
    pe = mon_valid_in & mon_ready_in & mon_last_in;
    if (!rst_n) begin
      m_has_grant = 0; m_hdr_waiting = 0; m_end_early = 0;
      m_last = N - 1; m_gid = 0; m_d = '0; m_k = '0; m_c = '0; m_err = 0;
    end else begin
      m_err = 0;
      if (!m_has_grant) begin
        w = rr_pick(req_valid, m_last);
        if (w >= 0) begin
          m_has_grant = 1; m_hdr_waiting = 1; m_end_early = 0;
          m_last = w; m_gid = w;
          m_d = hd[2'(w)]; m_k = hk[2'(w)]; m_c = hc[2'(w)];
          m_err = (32'(hk[2'(w)]) != ((32'd1 << (32'(hc[2'(w)]) + 1)) - 32'd1));
        end
      end else if (m_hdr_waiting) begin
        if (ready_insert) begin
          m_hdr_waiting = 0;
          if (m_end_early || pe) m_has_grant = 0;
          m_end_early = 0;
        end else if (pe) begin
          m_end_early = 1;
        end
      end else if (pe) begin
        m_has_grant = 0;
      end
    end
  endtask

  // Called after the negedge sampling point: model compare, advance, next edge
  task automatic finish_cycle();
    model_check();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mon(input bit v);
    mon_valid_in = v; mon_ready_in = v; mon_last_in = v;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       rst;
    logic [3:0] rv;
    logic       rdy;
    logic       pe;
    logic       vld;
    logic       act;
    logic [1:0] gid;
    logic [3:0] rr;
    logic       err;
  } vec_t;

  function automatic vec_t mk(input int rst, input int rv, input int rdy, input int pe,
                              input int vld, input int act, input int gid, input int rr,
                              input int err);
    vec_t v;
    v.rst = 1'(rst); v.rv = 4'(rv); v.rdy = 1'(rdy); v.pe = 1'(pe);
    v.vld = 1'(vld); v.act = 1'(act); v.gid = 2'(gid); v.rr = 4'(rr); v.err = 1'(err);
    return v;
  endfunction

  vec_t tbl [23];

  initial begin
    int   got [$];
    int   beat;
    bit   act_s;

    //            rst rv  rdy pe | vld act gid rr  err
    tbl[0]  = mk(0, 'hF, 0, 0,   0, 0, 0, 'h0, 0);  // reset with all requesting
    tbl[1]  = mk(0, 'hF, 0, 0,   0, 0, 0, 'h0, 0);
    tbl[2]  = mk(0, 'hF, 0, 0,   0, 0, 0, 'h0, 0);
    tbl[3]  = mk(1, 'hF, 0, 0,   0, 0, 0, 'h1, 0);  // first capture: requester 0
    tbl[4]  = mk(1, 'hF, 1, 0,   1, 1, 0, 'h0, 0);  // accept, packet still running
    tbl[5]  = mk(1, 'hF, 1, 0,   0, 1, 0, 'h0, 0);
    tbl[6]  = mk(1, 'hF, 1, 1,   0, 1, 0, 'h0, 0);  // packet end
    tbl[7]  = mk(1, 'hF, 0, 0,   0, 0, 0, 'h2, 0);  // capture 1 (bad keep)
    tbl[8]  = mk(1, 'hF, 0, 1,   1, 1, 1, 'h0, 1);  // early last, err pulse
    tbl[9]  = mk(1, 'hF, 1, 0,   1, 1, 1, 'h0, 0);  // accept -> straight to idle
    tbl[10] = mk(1, 'hF, 1, 0,   0, 0, 1, 'h4, 0);  // next capture immediately
    tbl[11] = mk(1, 'hF, 1, 1,   1, 1, 2, 'h0, 0);  // accept with coincident end
    tbl[12] = mk(1, 'h9, 0, 0,   0, 0, 2, 'h8, 0);  // 0 and 3 pending -> 3
    tbl[13] = mk(1, 'h9, 1, 0,   1, 1, 3, 'h0, 0);
    tbl[14] = mk(1, 'h9, 0, 1,   0, 1, 3, 'h0, 0);
    tbl[15] = mk(1, 'h9, 0, 0,   0, 0, 3, 'h1, 0);  // wrap to 0
    tbl[16] = mk(1, 'h0, 0, 0,   1, 1, 0, 'h0, 0);  // header held
    tbl[17] = mk(1, 'h0, 1, 0,   1, 1, 0, 'h0, 0);
    tbl[18] = mk(1, 'h0, 0, 0,   0, 1, 0, 'h0, 0);  // mid-packet
    tbl[19] = mk(0, 'h9, 0, 0,   0, 1, 0, 'h0, 0);  // reset while busy
    tbl[20] = mk(1, 'h9, 0, 0,   0, 0, 0, 'h1, 0);  // pointer restored: 0 wins
    tbl[21] = mk(1, 'h0, 1, 1,   1, 1, 0, 'h0, 0);
    tbl[22] = mk(1, 'h0, 0, 0,   0, 0, 0, 'h0, 0);

    for (int i = 0; i < N; i++) begin
      hd[i] = DW'(16'hC000 + i);
      hk[i] = (i == 1) ? 2'b10 : 2'b11;
      hc[i] = (i == 1) ? 1'b0 : 1'b1;
    end
    rst_n = 1'b0; req_valid = '0; ready_insert = 1'b0; set_mon(1'b0);
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;

    for (int i = 0; i < 23; i++) begin
      rst_n = tbl[i].rst; req_valid = tbl[i].rv; ready_insert = tbl[i].rdy;
      set_mon(tbl[i].pe);
      @(negedge clk);
      chk($sformatf("tbl%0d.valid_insert", i), 64'(valid_insert), 64'(tbl[i].vld));
      chk($sformatf("tbl%0d.grant_active", i), 64'(grant_active), 64'(tbl[i].act));
      chk($sformatf("tbl%0d.grant_id", i),     64'(grant_id),     64'(tbl[i].gid));
      chk($sformatf("tbl%0d.req_ready", i),    64'(req_ready),    64'(tbl[i].rr));
      chk($sformatf("tbl%0d.hdr_err", i),      64'(hdr_err),      64'(tbl[i].err));
      if (tbl[i].act) begin
        chk($sformatf("tbl%0d.data_insert", i), 64'(data_insert), 64'(hd[tbl[i].gid]));
        chk($sformatf("tbl%0d.keep_insert", i), 64'(keep_insert), 64'(hk[tbl[i].gid]));
      end
      finish_cycle();
    end

    // ---------------- single request with a stalled inserter ----------------
    hd[2] = 16'hABCD; hk[2] = 2'b11; hc[2] = 1'b1;
    req_valid = 4'b0100; ready_insert = 1'b0; set_mon(1'b0);
    @(negedge clk);
    chk("single.req_ready", 64'(req_ready), 64'(4'b0100));
    finish_cycle();
    req_valid = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("single.valid_hold", 64'(valid_insert), 64'd1);
      chk("single.data_hold",  64'(data_insert),  64'(16'hABCD));
      chk("single.req_ready0", 64'(req_ready),    64'd0);
      finish_cycle();
    end
    ready_insert = 1'b1;
    @(negedge clk);
    chk("single.valid_accept", 64'(valid_insert), 64'd1);
    finish_cycle();
    ready_insert = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("single.busy_active", 64'(grant_active), 64'd1);
      chk("single.busy_valid",  64'(valid_insert), 64'd0);
      finish_cycle();
    end
    set_mon(1'b1);
    @(negedge clk);
    chk("single.end_active", 64'(grant_active), 64'd1);
    finish_cycle();
    set_mon(1'b0);
    @(negedge clk);
    chk("single.after_end", 64'(grant_active), 64'd0);
    finish_cycle();

    // ---------------- fairness: everyone requesting, 3-beat packets ----------
    rst_n = 1'b0; req_valid = '1;
    @(negedge clk);
    finish_cycle();
    rst_n = 1'b1; ready_insert = 1'b1; beat = 0;
    for (int c = 0; c < 80 && got.size() < 6; c++) begin
      mon_ready_in = 1'b1;
      mon_valid_in = grant_active;
      mon_last_in  = grant_active && (beat == 2);
      @(negedge clk);
      if (valid_insert) got.push_back(int'(grant_id));
      act_s = grant_active;
      finish_cycle();
      if (act_s) beat = (beat == 2) ? 0 : beat + 1;
    end
    chk("fair.count", 64'(got.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("fair.gid%0d", i), (i < got.size()) ? 64'(got[i]) : '1, 64'(i % 4));

    // ---------------- randomized traffic against the model -------------------
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(99) != 0);
      req_valid = N'($urandom);
      for (int i = 0; i < N; i++) begin
        hd[i] = DW'($urandom);
        hk[i] = BW'($urandom);
        hc[i] = CW'($urandom);
      end
      ready_insert = 1'($urandom_range(1));
      mon_valid_in = 1'($urandom_range(1));
      mon_ready_in = 1'($urandom_range(1));
      mon_last_in  = ($urandom_range(2) == 0);
      @(negedge clk);
      finish_cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule : tb_axi_stream_header_arbiter
`default_nettype wire

// File: doc/axi_stream_header_arbiter.md
# axi_stream_header_arbiter

Round-robin controller that shares the single header-insert port of `axi_stream_insert_header` among `NUM_REQ` header sources. It grants exactly one header per packet. The granted header is presented on the inserter's insert channel, and the grant is held until the inserter's payload input completes its `last` beat. Only then is the next requester served. The block sits directly in front of the inserter's `valid_insert`/`ready_insert` port and passively monitors the payload input handshake.

## Interface
Parameters:
- `DATA_WD`, 16, header/data width in bits
- `DATA_BYTE_WD`, `DATA_WD/8`, bytes per beat
- `BYTE_CNT_WD`, `$clog2(DATA_BYTE_WD)`, width of byte count
- `NUM_REQ`, 4, number of header requesters (≥2)
- `REQ_ID_WD`, `$clog2(NUM_REQ)`, grant index width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  `NUM_REQ`  per-requester header valid
- `req_data`  in  `NUM_REQ*DATA_WD`  packed headers; requester i at `[i*DATA_WD +: DATA_WD]`
- `req_keep`  in  `NUM_REQ*DATA_BYTE_WD`  packed header keep masks
- `req_byte_cnt`  in  `NUM_REQ*BYTE_CNT_WD`  packed header byte counts
- `req_ready`  out  `NUM_REQ`  one-hot capture strobe to the granted requester
- `valid_insert`  out  1  header valid to the inserter
- `data_insert`  out  `DATA_WD`  granted header
- `keep_insert`  out  `DATA_BYTE_WD`  granted keep
- `byte_insert_cnt`  out  `BYTE_CNT_WD`  granted byte count
- `ready_insert`  in  1  inserter accepts header
- `mon_valid_in`, `mon_ready_in`, `mon_last_in`  in  1 each  copies of the inserter's payload `valid_in`/`ready_in`/`last_in`
- `grant_id`  out  `REQ_ID_WD`  index of current grant
- `grant_active`  out  1  a grant is in progress (states `OFFER` or `BUSY`)
- `hdr_err`  out  1  one-cycle pulse: captured keep inconsistent with byte count

## Operation
- Define `pkt_end = mon_valid_in & mon_ready_in & mon_last_in`.
- FSM states: `IDLE`, `OFFER`, `BUSY`.
- `IDLE`:
  - If any `req_valid`, select winner i = first set bit searching from `(rr_ptr+1) mod NUM_REQ` upward with wrap.
  - Assert `req_ready[i]` combinationally in the same cycle.
  - On the clock edge: capture `req_data`/`req_keep`/`req_byte_cnt` of i into the output registers, set `grant_id=i`, set `rr_ptr=i`, go to `OFFER`.
  - With no request, remain in `IDLE`.
- `OFFER`:
  - `valid_insert=1`; all insert outputs are held stable until `ready_insert`.
  - A `pkt_end` seen in this state sets sticky `pend_last`.
  - On `valid_insert & ready_insert`: go to `IDLE` if `pend_last` or `pkt_end` occurs in the same cycle; otherwise go to `BUSY`. `pend_last` is cleared on this transition.
- `BUSY`: on `pkt_end`, go to `IDLE`.
- `req_ready` is 0 outside `IDLE`, and never depends on `ready_insert`.
- `hdr_err` pulses in the cycle after capture when `req_keep[i] != (2^(byte_cnt+1))-1`. The header is still forwarded unchanged.
- Data, keep and byte count are forwarded unmodified; the block performs no width arithmetic beyond the keep check.

## Timing
- Reset values: all outputs are 0; state is `IDLE`; `rr_ptr = NUM_REQ-1`, so requester 0 has first priority; `pend_last` is 0.
- Latency: a request captured at edge N gives `valid_insert=1` from cycle N+1.
- Minimum spacing between consecutive captures is 2 cycles (capture, then `OFFER` with immediate accept and a coincident or earlier `pkt_end`).
- `valid_insert` is registered and never withdrawn before the handshake completes.
- Simultaneous `ready_insert` and `pkt_end` in `OFFER` → `IDLE` directly.
- A requester that drops `req_valid` before its capture loses its turn with no penalty; the round-robin pointer moves only on capture.
- Reset asserted in any state: the next edge returns to reset values, with no partial handshake on `valid_insert`.

## Structure
- Shared package `axi_hdr_pkg` holds:
  - the state enum `{IDLE, OFFER, BUSY}`;
  - the function `keep_from_cnt(cnt)` returning `(2^(cnt+1))-1`, which is reused by benches and the inserter checker.
- One natural sub-module: `hdr_rr_arbiter`. It is a combinational round-robin picker with inputs `req`, `ptr` and outputs `gnt_onehot`, `gnt_idx`, `any`. The FSM and registers stay in the top level.

## Test plan
- Reset: hold `rst_n=0` 3 cycles with all `req_valid=1` → all outputs 0, `req_ready=0`. After release, first capture goes to requester 0.
- Single request: requester 2 sends `data=16'hABCD`, `keep=2'b11`, `cnt=1`; `ready_insert` held low 3 cycles → `req_ready=4'b0100` for one cycle, then `valid_insert` stays 1 with `data_insert=16'hABCD` and stable for 3 cycles. Accept, then `grant_active` stays 1 until `pkt_end`.
- Fairness: all 4 requesting continuously, each packet 3 beats, `ready_insert=1` → `grant_id` sequence 0,1,2,3,0,1; no requester served twice before the others.
- Early last: `pkt_end` occurs while in `OFFER` before `ready_insert` → after the accept the FSM goes to `IDLE` without entering `BUSY`, and the next capture happens the following cycle.
- Keep error: requester 1 sends `keep=2'b10`, `cnt=0` → `hdr_err` high exactly one cycle, `keep_insert=2'b10` forwarded.
- Reset in `BUSY`: `rst_n=0` for 1 cycle mid-packet → next cycle `valid_insert=0`, `grant_active=0`; with requesters 0 and 3 pending, the next grant is `grant_id=0`.
